// File: rtl/nmos_clk_gen_if.sv
// Phase-enable bus between the clock generator and its consumers.
// Handshake: run is a level enable and step a request, both sampled on the clock edge; outputs are registered decodes.
interface nmos_clk_gen_if #(
  parameter int CYC_W = 32
);
  logic             run;
  logic             step;
  logic             phi1;
  logic             phi2;
  logic             phi1_stb;
  logic             phi2_stb;
  logic             idle;
  logic [CYC_W-1:0] cyc_cnt;
  logic [2:0]       dbg_state;

  modport master (
    output run, step,
    input  phi1, phi2, phi1_stb, phi2_stb, idle, cyc_cnt, dbg_state
  );

  modport slave (
    input  run, step,
    output phi1, phi2, phi1_stb, phi2_stb, idle, cyc_cnt, dbg_state
  );
endinterface

// File: rtl/nmos_clk_gen.sv
// Two-phase non-overlapping clock generator: P1 -> G12 -> P2 -> G21 windows derived from main_clk.
// All outputs decode from registered state; a started NMOS cycle always runs through G21.
module nmos_clk_gen #(
  parameter int PHI1_LEN = 2,
  parameter int GAP12    = 1,
  parameter int PHI2_LEN = 2,
  parameter int GAP21    = 1,
  parameter int CYC_W    = 32
) (
  input  logic          main_clk,
  input  logic          main_rst,
  nmos_clk_gen_if.slave bus
);

  if (PHI1_LEN < 1 || GAP12 < 1 || PHI2_LEN < 1 || GAP21 < 1) begin : g_bad_param
    $error("nmos_clk_gen: every phase and gap length must be at least 1");
  end

  localparam int M_A     = (PHI1_LEN > GAP12) ? PHI1_LEN : GAP12;
  localparam int M_B     = (PHI2_LEN > GAP21) ? PHI2_LEN : GAP21;
  localparam int MAX_LEN = (M_A > M_B) ? M_A : M_B;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] L_P1  = CNT_W'(PHI1_LEN - 1);
  localparam logic [CNT_W-1:0] L_G12 = CNT_W'(GAP12 - 1);
  localparam logic [CNT_W-1:0] L_P2  = CNT_W'(PHI2_LEN - 1);
  localparam logic [CNT_W-1:0] L_G21 = CNT_W'(GAP21 - 1);

  typedef enum logic [2:0] {
    HALT = 3'd0,
    P1   = 3'd1,
    G12  = 3'd2,
    P2   = 3'd3,
    G21  = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_sub;   // cycles remaining in the current state, minus one
  logic [CYC_W-1:0] r_cyc;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_sub_nxt;
  logic [CYC_W-1:0] w_cyc_nxt;
  logic             w_last;

  always_ff @(posedge main_clk) begin
    if (main_rst) begin
      r_state <= HALT;
      r_sub   <= '0;
      r_cyc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sub   <= w_sub_nxt;
      r_cyc   <= w_cyc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sub_nxt   = r_sub;
    w_cyc_nxt   = r_cyc;
    w_last      = (r_sub == '0);
    if (r_state != HALT && !w_last) begin
      w_sub_nxt = r_sub - 1'b1;
    end else begin
      case (r_state)
        HALT: begin
          // step while halted behaves like a one-cycle run; it is only looked at here
          if (bus.run || bus.step) begin
            w_state_nxt = P1;
            w_sub_nxt   = L_P1;
          end
        end
        P1: begin
          w_state_nxt = G12;
          w_sub_nxt   = L_G12;
        end
        G12: begin
          w_state_nxt = P2;
          w_sub_nxt   = L_P2;
        end
        P2: begin
          w_state_nxt = G21;
          w_sub_nxt   = L_G21;
        end
        G21: begin
          w_cyc_nxt = r_cyc + CYC_W'(1);
          if (bus.run) begin
            w_state_nxt = P1;
            w_sub_nxt   = L_P1;
          end else begin
            w_state_nxt = HALT;
            w_sub_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = HALT;
          w_sub_nxt   = '0;
        end
      endcase
    end
  end

  assign bus.phi1      = (r_state == P1);
  assign bus.phi2      = (r_state == P2);
  assign bus.phi1_stb  = (r_state == P1) && (r_sub == L_P1);
  assign bus.phi2_stb  = (r_state == P2) && (r_sub == L_P2);
  assign bus.idle      = (r_state == HALT);
  assign bus.cyc_cnt   = r_cyc;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_nmos_clk_gen.sv
// Bench for nmos_clk_gen: hand-derived vector table, randomized run/step/reset against a
// position-in-period model, and a non-default-parameter instance with counter wrap.
module tb_nmos_clk_gen;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  always #5 clk = ~clk;

  nmos_clk_gen_if #(.CYC_W(32)) ifa ();
  nmos_clk_gen_if #(.CYC_W(2))  ifb ();

  nmos_clk_gen dut_a (
    .main_clk (clk),
    .main_rst (rst_a),
    .bus      (ifa.slave)
  );

  nmos_clk_gen #(
    .PHI1_LEN (3),
    .GAP12    (2),
    .PHI2_LEN (1),
    .GAP21    (2),
    .CYC_W    (2)
  ) dut_b (
    .main_clk (clk),
    .main_rst (rst_b),
    .bus      (ifb.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // packed observation: {phi1, phi2, phi1_stb, phi2_stb, idle, cyc_cnt[31:0]}
  logic [36:0] exp_q[$];

  localparam logic [4:0] S_HALT = 5'b00001;
  localparam logic [4:0] S_P1S  = 5'b10100;
  localparam logic [4:0] S_P1   = 5'b10000;
  localparam logic [4:0] S_GAP  = 5'b00000;
  localparam logic [4:0] S_P2S  = 5'b01010;
  localparam logic [4:0] S_P2   = 5'b01000;

  typedef struct {
    logic        rst;
    logic        run;
    logic        step;
    logic [4:0]  sig;
    logic [31:0] cyc;
  } vec_t;

  vec_t tbl[36];

  function automatic vec_t mk(logic rst, logic run, logic step, logic [4:0] sig, int cyc);
    vec_t v;
    v.rst  = rst;
    v.run  = run;
    v.step = step;
    v.sig  = sig;
    v.cyc  = 32'(cyc);
    return v;
  endfunction

  function automatic logic [36:0] obs_a();
    return {ifa.phi1, ifa.phi2, ifa.phi1_stb, ifa.phi2_stb, ifa.idle, ifa.cyc_cnt};
  endfunction

  task automatic check(input string nm, input logic [36:0] act, input logic [36:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive_a(input logic rst, input logic run, input logic step);
    rst_a    = rst;
    ifa.run  = run;
    ifa.step = step;
  endtask

  // reference model: whole NMOS cycle seen as a position 0..PER-1 within the period
  localparam int PER  = 6;
  localparam int P2AT = 3;
  bit          m_active;
  int          m_pos;
  logic [31:0] m_cnt;

  task automatic model_step(input logic rst, input logic run, input logic step);
    if (rst) begin
      m_active = 1'b0;
      m_pos    = 0;
      m_cnt    = '0;
    end else if (!m_active) begin
      if (run || step) begin
        m_active = 1'b1;
        m_pos    = 0;
      end
    end else begin
      m_pos++;
      if (m_pos == PER) begin
        m_cnt++;
        m_pos = 0;
        if (!run) m_active = 1'b0;
      end
    end
  endtask

  function automatic logic [36:0] model_exp();
    logic p1, p2;
    p1 = m_active && (m_pos < 2);
    p2 = m_active && (m_pos >= P2AT) && (m_pos < P2AT + 2);
    return {p1, p2, m_active && m_pos == 0, m_active && m_pos == P2AT, !m_active, m_cnt};
  endfunction

  initial begin
    logic [36:0] e;
    ifa.run  = 1'b0;
    ifa.step = 1'b0;
    ifb.run  = 1'b0;
    ifb.step = 1'b0;

    tbl[0]  = mk(1, 1, 0, S_HALT, 0);
    tbl[1]  = mk(1, 1, 0, S_HALT, 0);
    tbl[2]  = mk(1, 1, 0, S_HALT, 0);
    tbl[3]  = mk(0, 1, 0, S_P1S,  0);
    tbl[4]  = mk(0, 1, 0, S_P1,   0);
    tbl[5]  = mk(0, 1, 0, S_GAP,  0);
    tbl[6]  = mk(0, 1, 0, S_P2S,  0);
    tbl[7]  = mk(0, 1, 0, S_P2,   0);
    tbl[8]  = mk(0, 1, 0, S_GAP,  0);
    tbl[9]  = mk(0, 1, 0, S_P1S,  1);
    tbl[10] = mk(0, 1, 0, S_P1,   1);
    tbl[11] = mk(0, 1, 0, S_GAP,  1);
    tbl[12] = mk(0, 1, 0, S_P2S,  1);
    tbl[13] = mk(0, 1, 0, S_P2,   1);
    tbl[14] = mk(0, 1, 0, S_GAP,  1);
    tbl[15] = mk(0, 1, 0, S_P1S,  2);
    tbl[16] = mk(0, 1, 0, S_P1,   2);
    tbl[17] = mk(0, 1, 0, S_GAP,  2);
    tbl[18] = mk(0, 1, 0, S_P2S,  2);
    tbl[19] = mk(0, 0, 0, S_P2,   2);
    tbl[20] = mk(0, 0, 0, S_GAP,  2);
    tbl[21] = mk(0, 0, 0, S_HALT, 3);
    tbl[22] = mk(0, 0, 0, S_HALT, 3);
    tbl[23] = mk(0, 0, 1, S_P1S,  3);
    tbl[24] = mk(0, 0, 0, S_P1,   3);
    tbl[25] = mk(0, 0, 0, S_GAP,  3);
    tbl[26] = mk(0, 0, 1, S_P2S,  3);
    tbl[27] = mk(0, 0, 0, S_P2,   3);
    tbl[28] = mk(0, 0, 0, S_GAP,  3);
    tbl[29] = mk(0, 0, 0, S_HALT, 4);
    tbl[30] = mk(0, 0, 0, S_HALT, 4);
    tbl[31] = mk(0, 1, 0, S_P1S,  4);
    tbl[32] = mk(0, 1, 0, S_P1,   4);
    tbl[33] = mk(1, 1, 0, S_HALT, 0);
    tbl[34] = mk(0, 0, 0, S_HALT, 0);
    tbl[35] = mk(0, 0, 0, S_HALT, 0);

    // directed table: reset, free run, stop mid-phase, single step, reset mid-phase
    for (int i = 0; i < 36; i++) begin
      drive_a(tbl[i].rst, tbl[i].run, tbl[i].step);
      @(posedge clk);
      #1;
      check($sformatf("table[%0d]", i), obs_a(), {tbl[i].sig, tbl[i].cyc});
    end

    // randomized run/step/reset against the model
    for (int i = 0; i < 400; i++) begin
      logic r, rn, st;
      r  = (i == 0) || ($urandom_range(0, 63) == 0);
      rn = ($urandom_range(0, 9) < 4);
      st = ($urandom_range(0, 3) == 0);
      drive_a(r, rn, st);
      model_step(r, rn, st);
      exp_q.push_back(model_exp());
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("random[%0d]", i), obs_a(), e);
      if (ifa.phi1 && ifa.phi2) check("overlap", 37'(1), 37'(0));
    end
    drive_a(1'b0, 1'b0, 1'b0);

    // non-default lengths (period 8) with a 2-bit counter that wraps
    rst_b   = 1'b1;
    ifb.run = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("b_reset", {29'd0, ifb.phi1, ifb.phi2, ifb.phi1_stb, ifb.phi2_stb, ifb.idle, ifb.cyc_cnt},
          {29'd0, 5'b00001, 2'd0});
    rst_b = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      int pos;
      logic [1:0] ec;
      pos = (c - 1) % 8;
      ec  = 2'(((c - 1) / 8) % 4);
      @(posedge clk);
      #1;
      check($sformatf("b_cycle[%0d]", c),
            {29'd0, ifb.phi1, ifb.phi2, ifb.phi1_stb, ifb.phi2_stb, ifb.idle, ifb.cyc_cnt},
            {29'd0, pos < 3, pos == 5, pos == 0, pos == 5, 1'b0, ec});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
